filter_mode_ctrl: RTL and testbench

- Controller for the per-pixel filter datapath (inversion and sibling filters) in the video pipeline.
- Synchronises and debounces the board switches, validates the requested filter mode, and applies a mode change only at a frame boundary (vsync rising edge), so no frame is ever half-filtered.
- Enforces a minimum number of frames between changes, and provides a frame counter and status for the filters and debug LEDs.
- Sits beside the filter chain. Its o_mode replaces raw sw as the mode select of every filter.

---
 rtl/filter_mode_ctrl.sv | 157 +++++++++++++++
 tb/tb_filter_mode_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mode_ctrl.sv
// filter_mode_ctrl: debounced switch -> validated filter mode, applied only on a vsync rising edge.
// Optional auto-cycle on sw=4'hF when FILTER_AUTO_CYCLE_EN is defined.
//   state   | meaning
//   RUN     | o_mode matches request, watching for a new request
//   PENDING | validated request waiting for the next frame boundary
//   HOLD    | mode just changed, waiting MIN_HOLD_FRAMES vsync edges
module filter_mode_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [3:0]  NUM_MODES       = 4'd4,
  parameter logic [3:0]  MIN_HOLD_FRAMES = 4'd2,
  parameter logic [7:0]  AUTO_FRAMES     = 8'd60
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_vid_vsync,
  input  logic        i_vid_VDE,
  input  logic [3:0]  sw,
  output logic [3:0]  o_mode,
  output logic        o_mode_change,
  output logic        o_pending,
  output logic [15:0] o_frame_cnt,
  output logic        o_in_blank
);

  typedef enum logic [1:0] {RUN, PENDING, HOLD} state_t;

  localparam logic [15:0] DB_LAST = DEBOUNCE_CYCLES - 16'd1;

  logic [3:0]  sync1, sync2, cand, stable;
  logic [15:0] db_cnt;
  logic        vsync_d, vs_edge;
  logic [3:0]  valid_mode, req_mode;
  state_t      state, state_nx;
  logic [3:0]  hold_cnt, hold_nx, mode_nx;
  logic        pending_nx, change_nx;

  // Debounce timer counts down from DB_LAST; stable follows cand once it hits zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1  <= 4'd0;
      sync2  <= 4'd0;
      cand   <= 4'd0;
      stable <= 4'd0;
      db_cnt <= 16'd0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand   <= sync2;
        db_cnt <= DB_LAST;
      end else if (db_cnt != 16'd0) begin
        db_cnt <= db_cnt - 16'd1;
      end
      if (db_cnt == 16'd0) stable <= cand;
    end
  end

  assign vs_edge = i_vid_vsync & ~vsync_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vsync_d     <= 1'b0;
      o_frame_cnt <= 16'd0;
      o_in_blank  <= 1'b0;
    end else begin
      vsync_d    <= i_vid_vsync;
      o_in_blank <= ~i_vid_VDE;
      if (vs_edge) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

  assign valid_mode = (stable < NUM_MODES) ? stable : 4'd0;

`ifdef FILTER_AUTO_CYCLE_EN
  localparam logic [7:0] AUTO_LAST = AUTO_FRAMES - 8'd1;

  logic [3:0] auto_mode;
  logic [7:0] auto_left;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      auto_mode <= 4'd1;
      auto_left <= AUTO_LAST;
    end else if (stable != 4'hF) begin
      auto_mode <= 4'd1;
      auto_left <= AUTO_LAST;
    end else if (vs_edge) begin
      if (auto_left == 8'd0) begin
        auto_left <= AUTO_LAST;
        auto_mode <= (auto_mode >= NUM_MODES - 4'd1) ? 4'd1 : auto_mode + 4'd1;
      end else begin
        auto_left <= auto_left - 8'd1;
      end
    end
  end

  assign req_mode = (stable == 4'hF) ? auto_mode : valid_mode;
`else
  logic unused_auto;
  assign unused_auto = ^AUTO_FRAMES;
  assign req_mode    = valid_mode;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= RUN;
      o_mode        <= 4'd0;
      o_pending     <= 1'b0;
      o_mode_change <= 1'b0;
      hold_cnt      <= 4'd0;
    end else begin
      state         <= state_nx;
      o_mode        <= mode_nx;
      o_pending     <= pending_nx;
      o_mode_change <= change_nx;
      hold_cnt      <= hold_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    mode_nx    = o_mode;
    pending_nx = o_pending;
    change_nx  = 1'b0;
    hold_nx    = hold_cnt;
    case (state)
      RUN: begin
        if (req_mode != o_mode) begin
          state_nx   = PENDING;
          pending_nx = 1'b1;
        end
      end
      PENDING: begin
        if (req_mode == o_mode) begin
          state_nx   = RUN;
          pending_nx = 1'b0;
        end else if (vs_edge) begin
          state_nx   = HOLD;
          mode_nx    = req_mode;
          change_nx  = 1'b1;
          pending_nx = 1'b0;
          hold_nx    = MIN_HOLD_FRAMES;
        end
      end
      HOLD: begin
        // Hold timer counts vsync edges down; RUN picks up any queued request afterwards.
        if (hold_cnt == 4'd0) state_nx = RUN;
        else if (vs_edge) hold_nx = hold_cnt - 4'd1;
      end
      default: begin
        state_nx   = RUN;
        pending_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_filter_mode_ctrl.sv
// tb_filter_mode_ctrl: directed scenarios for filter_mode_ctrl with
// DEBOUNCE_CYCLES=4, NUM_MODES=4, MIN_HOLD_FRAMES=2.
module tb_filter_mode_ctrl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        vsync = 1'b0;
  logic        vde = 1'b0;
  logic [3:0]  sw = 4'd0;
  logic [3:0]  mode;
  logic        mode_change;
  logic        pending;
  logic [15:0] frame_cnt;
  logic        in_blank;

  int checks = 0;
  int failures = 0;

  filter_mode_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .NUM_MODES(4'd4),
    .MIN_HOLD_FRAMES(4'd2),
    .AUTO_FRAMES(8'd3)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .i_vid_vsync(vsync),
    .i_vid_VDE(vde),
    .sw(sw),
    .o_mode(mode),
    .o_mode_change(mode_change),
    .o_pending(pending),
    .o_frame_cnt(frame_cnt),
    .o_in_blank(in_blank)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge right after the posedge that saw the vsync rise.
  task automatic pulse_vsync();
    vsync = 1'b1;
    @(negedge clk);
    vsync = 1'b0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    sw    = 4'd0;
    vsync = 1'b0;
    vde   = 1'b1;
    tick(3);
    n_rst = 1'b1;
    tick(1);
  endtask

  // Switch to mode m from RUN and then consume both hold frames.
  task automatic set_mode(input logic [3:0] m);
    sw = m;
    tick(10);
    pulse_vsync();
    tick(3);
    pulse_vsync();
    tick(3);
    pulse_vsync();
    tick(3);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    vde   = 1'b0;
    sw    = 4'h5;
    tick(3);
    if ({mode, mode_change, pending, frame_cnt, in_blank} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: got mode=%0h chg=%0b pend=%0b frm=%0h blank=%0b required all zero",
               mode, mode_change, pending, frame_cnt, in_blank);
    end
    checks++;
    n_rst = 1'b1;
    sw    = 4'd0;
    tick(1);
    if (in_blank !== 1'b1) begin
      failures++;
      $display("FAIL blank_hi: got %0b required 1", in_blank);
    end
    checks++;
    vde = 1'b1;
    tick(1);
    if (in_blank !== 1'b0) begin
      failures++;
      $display("FAIL blank_lo: got %0b required 0", in_blank);
    end
    checks++;
  endtask

  task automatic test_basic_switch();
    do_reset();
    sw = 4'd2;
    tick(7);
    if (pending !== 1'b0) begin
      failures++;
      $display("FAIL pend_early: got %0b required 0", pending);
    end
    checks++;
    tick(1);
    if (pending !== 1'b1 || mode !== 4'd0) begin
      failures++;
      $display("FAIL pend_rise: got pend=%0b mode=%0h required pend=1 mode=0", pending, mode);
    end
    checks++;
    tick(12);
    pulse_vsync();
    if (mode !== 4'd2 || mode_change !== 1'b1 || pending !== 1'b0 || frame_cnt !== 16'd1) begin
      failures++;
      $display("FAIL basic_switch: got mode=%0h chg=%0b pend=%0b frm=%0h required 2 1 0 1",
               mode, mode_change, pending, frame_cnt);
    end
    checks++;
    tick(1);
    if (mode_change !== 1'b0 || mode !== 4'd2) begin
      failures++;
      $display("FAIL chg_one_cycle: got chg=%0b mode=%0h required 0 2", mode_change, mode);
    end
    checks++;
  endtask

  task automatic test_bounce();
    logic seen;
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sw = (i % 2 == 0) ? 4'd2 : 4'd0;
      tick(1);
      seen = seen | pending;
      tick(1);
      seen = seen | pending;
    end
    sw = 4'd0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen = seen | pending;
    end
    if (seen !== 1'b0 || mode !== 4'd0) begin
      failures++;
      $display("FAIL bounce: got seen_pend=%0b mode=%0h required 0 0", seen, mode);
    end
    checks++;
  endtask

  task automatic test_cancel();
    logic seen_chg;
    do_reset();
    set_mode(4'd2);
    sw = 4'd3;
    tick(8);
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL cancel_pend_set: got %0b required 1", pending);
    end
    checks++;
    sw = 4'd2;
    seen_chg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      seen_chg = seen_chg | mode_change;
    end
    if (pending !== 1'b0) begin
      failures++;
      $display("FAIL cancel_pend_clr: got %0b required 0", pending);
    end
    checks++;
    pulse_vsync();
    seen_chg = seen_chg | mode_change;
    if (seen_chg !== 1'b0 || mode !== 4'd2) begin
      failures++;
      $display("FAIL cancel_mode: got chg=%0b mode=%0h required 0 2", seen_chg, mode);
    end
    checks++;
  endtask

  task automatic test_hold();
    do_reset();
    sw = 4'd1;
    tick(10);
    pulse_vsync();
    sw = 4'd3;
    tick(10);
    if (pending !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_pend: got %0b required 0", pending);
    end
    checks++;
    pulse_vsync();
    if (mode !== 4'd1 || mode_change !== 1'b0) begin
      failures++;
      $display("FAIL hold_edge1: got mode=%0h chg=%0b required 1 0", mode, mode_change);
    end
    checks++;
    tick(3);
    pulse_vsync();
    if (mode !== 4'd1) begin
      failures++;
      $display("FAIL hold_edge2: got mode=%0h required 1", mode);
    end
    checks++;
    tick(3);
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL hold_release_pend: got %0b required 1", pending);
    end
    checks++;
    pulse_vsync();
    if (mode !== 4'd3 || mode_change !== 1'b1 || frame_cnt !== 16'd4) begin
      failures++;
      $display("FAIL hold_apply: got mode=%0h chg=%0b frm=%0h required 3 1 4", mode, mode_change, frame_cnt);
    end
    checks++;
  endtask

  task automatic test_coincident_edge();
    do_reset();
    sw = 4'd1;
    tick(7);
    vsync = 1'b1;
    tick(1);
    vsync = 1'b0;
    if (pending !== 1'b1 || mode !== 4'd0 || mode_change !== 1'b0) begin
      failures++;
      $display("FAIL coincident: got pend=%0b mode=%0h chg=%0b required 1 0 0", pending, mode, mode_change);
    end
    checks++;
    tick(3);
    pulse_vsync();
    if (mode !== 4'd1 || frame_cnt !== 16'd2) begin
      failures++;
      $display("FAIL coincident_apply: got mode=%0h frm=%0h required 1 2", mode, frame_cnt);
    end
    checks++;
  endtask

  task automatic test_latest();
    do_reset();
    sw = 4'd2;
    tick(9);
    sw = 4'd3;
    tick(9);
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL latest_pend: got %0b required 1", pending);
    end
    checks++;
    pulse_vsync();
    if (mode !== 4'd3) begin
      failures++;
      $display("FAIL latest_mode: got %0h required 3", mode);
    end
    checks++;
  endtask

  task automatic test_out_of_range_and_reset();
    do_reset();
    set_mode(4'd2);
    sw = 4'd9;
    tick(8);
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL oor_pend: got %0b required 1", pending);
    end
    checks++;
    pulse_vsync();
    if (mode !== 4'd0 || mode_change !== 1'b1 || frame_cnt !== 16'd4) begin
      failures++;
      $display("FAIL oor_bypass: got mode=%0h chg=%0b frm=%0h required 0 1 4", mode, mode_change, frame_cnt);
    end
    checks++;
    tick(3);
    pulse_vsync();
    tick(3);
    pulse_vsync();
    tick(3);
    sw = 4'd2;
    tick(8);
    if (pending !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_pend: got %0b required 1", pending);
    end
    checks++;
    #2 n_rst = 1'b0;
    #1;
    if ({mode, mode_change, pending, frame_cnt, in_blank} !== 23'd0) begin
      failures++;
      $display("FAIL async_reset: got mode=%0h chg=%0b pend=%0b frm=%0h blank=%0b required all zero",
               mode, mode_change, pending, frame_cnt, in_blank);
    end
    checks++;
    tick(2);
    n_rst = 1'b1;
    tick(1);
  endtask

  task automatic test_frame_wrap();
    do_reset();
    @(negedge clk);
    force dut.o_frame_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.o_frame_cnt;
    tick(1);
    pulse_vsync();
    if (frame_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL frame_ffff: got %0h required ffff", frame_cnt);
    end
    checks++;
    tick(2);
    pulse_vsync();
    if (frame_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL frame_wrap: got %0h required 0", frame_cnt);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_basic_switch();
    test_bounce();
    test_cancel();
    test_hold();
    test_coincident_edge();
    test_latest();
    test_out_of_range_and_reset();
    test_frame_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
